// File: rtl/scan_decoder.sv
// One-hot code decoder with a direct handshake mode and a timed auto-scan mode.
// Define SCAN_DECODER_ACTIVE_LOW_EN for active-low outputs (selected bit 0, inactive all ones).
module scan_decoder #(
   parameter int N     = 4,
   parameter int DWELL = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            mode,
   input  logic            in_valid,
   input  logic [N-1:0]    in_code,
   output logic            in_ready,
   output logic [2**N-1:0] out,
   output logic [N-1:0]    cur_code,
   output logic            wrap
);

   // state  | meaning
   // IDLE   | disabled; outputs inactive, cur_code held, dwell cleared
   // DIRECT | decode in_code on each valid/ready handshake
   // SCAN   | step cur_code every DWELL cycles, pulse wrap on 2**N-1 -> 0

   localparam int OW = 2**N;
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
   localparam logic [OW-1:0] POL = {OW{1'b1}};
`else
   localparam logic [OW-1:0] POL = '0;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    cur_code_q, cur_code_d;
   logic [DW-1:0]   dwell_q, dwell_d;
   logic [OW-1:0]   out_q, out_d;
   logic            wrap_q, wrap_d;

   always_comb begin
      state_d    = state_q;
      cur_code_d = cur_code_q;
      dwell_d    = dwell_q;
      wrap_d     = 1'b0;
      if (!en) begin
         state_d = IDLE;
         dwell_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mode) begin
                  state_d    = SCAN;
                  cur_code_d = '0;
                  dwell_d    = '0;
               end else begin
                  state_d = DIRECT;
               end
            end
            DIRECT: begin
               // a mode change wins over a same-cycle handshake
               if (mode) begin
                  state_d    = SCAN;
                  cur_code_d = '0;
                  dwell_d    = '0;
               end else if (in_valid) begin
                  cur_code_d = in_code;
               end
            end
            SCAN: begin
               if (!mode) begin
                  state_d = DIRECT;
                  dwell_d = '0;
               end else if (dwell_q == DWELL_LAST) begin
                  dwell_d    = '0;
                  cur_code_d = cur_code_q + N'(1);
                  wrap_d     = (cur_code_q == {N{1'b1}});
               end else begin
                  dwell_d = dwell_q + DW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               dwell_d = '0;
            end
         endcase
      end

      if (state_d == IDLE)
         out_d = POL;
      else
         out_d = ({{(OW-1){1'b0}}, 1'b1} << cur_code_d) ^ POL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cur_code_q <= '0;
         dwell_q    <= '0;
         out_q      <= POL;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_code_q <= cur_code_d;
         dwell_q    <= dwell_d;
         out_q      <= out_d;
         wrap_q     <= wrap_d;
      end
   end

   assign in_ready = en && (state_q == DIRECT);
   assign out      = out_q;
   assign cur_code = cur_code_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder (N=4, DWELL=3) plus a DWELL=1 instance sharing stimulus.
module tb_scan_decoder;

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
   localparam logic [15:0] POL = 16'hFFFF;
`else
   localparam logic [15:0] POL = 16'h0000;
`endif

   logic        clk = 1'b0;
   logic        rst, en, mode, in_valid;
   logic [3:0]  in_code;
   logic        in_ready, wrap, in_ready1, wrap1;
   logic [15:0] out, out1;
   logic [3:0]  cur_code, cur_code1;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   scan_decoder #(.N(4), .DWELL(3)) u_dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
      .in_code(in_code), .in_ready(in_ready), .out(out), .cur_code(cur_code), .wrap(wrap)
   );

   scan_decoder #(.N(4), .DWELL(1)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
      .in_code(in_code), .in_ready(in_ready1), .out(out1), .cur_code(cur_code1), .wrap(wrap1)
   );

   function automatic logic [15:0] exp_out(input int c);
      logic [15:0] one;
      one = 16'h0001;
      return (one << c) ^ POL;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0; in_code = 4'd0;
      #2;
      total_cnt++;
      if (out !== POL) $display("FAIL reset_out got=%h exp=%h", out, POL); else pass_cnt++;
      total_cnt++;
      if (cur_code !== 4'd0) $display("FAIL reset_code got=%0d exp=0", cur_code); else pass_cnt++;
      total_cnt++;
      if (wrap !== 1'b0) $display("FAIL reset_wrap got=%b exp=0", wrap); else pass_cnt++;
      tick();
      rst = 1'b0;
      en = 1'b0; in_valid = 1'b1; in_code = 4'd9;
      tick();
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL idle_ready got=%b exp=0", in_ready); else pass_cnt++;
      total_cnt++;
      if (cur_code !== 4'd0) $display("FAIL idle_ignore got=%0d exp=0", cur_code); else pass_cnt++;
      in_valid = 1'b0;
   endtask

   task automatic test_direct();
      en = 1'b1; mode = 1'b0;
      tick();
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL direct_ready got=%b exp=1", in_ready); else pass_cnt++;
      total_cnt++;
      if (out !== exp_out(0)) $display("FAIL direct_entry_out got=%h exp=%h", out, exp_out(0)); else pass_cnt++;
      for (int c = 0; c < 16; c++) begin
         in_valid = 1'b1; in_code = 4'(c);
         tick();
         in_valid = 1'b0;
         total_cnt++;
         if (out !== exp_out(c)) $display("FAIL direct_out code=%0d got=%h exp=%h", c, out, exp_out(c)); else pass_cnt++;
         total_cnt++;
         if (cur_code !== 4'(c)) $display("FAIL direct_code got=%0d exp=%0d", cur_code, c); else pass_cnt++;
      end
      in_code = 4'd3;
      tick();
      total_cnt++;
      if (cur_code !== 4'd15) $display("FAIL direct_hold_code got=%0d exp=15", cur_code); else pass_cnt++;
      total_cnt++;
      if (out !== exp_out(15)) $display("FAIL direct_hold_out got=%h exp=%h", out, exp_out(15)); else pass_cnt++;
   endtask

   task automatic test_scan();
      int ec;
      mode = 1'b1;
      for (int k = 0; k < 50; k++) begin
         tick();
         ec = (k / 3) % 16;
         total_cnt++;
         if (cur_code !== 4'(ec)) $display("FAIL scan_code k=%0d got=%0d exp=%0d", k, cur_code, ec); else pass_cnt++;
         total_cnt++;
         if (out !== exp_out(ec)) $display("FAIL scan_out k=%0d got=%h exp=%h", k, out, exp_out(ec)); else pass_cnt++;
         total_cnt++;
         if (wrap !== (k == 48)) $display("FAIL scan_wrap k=%0d got=%b exp=%b", k, wrap, (k == 48)); else pass_cnt++;
         total_cnt++;
         if (in_ready !== 1'b0) $display("FAIL scan_ready k=%0d got=%b exp=0", k, in_ready); else pass_cnt++;
         total_cnt++;
         if (cur_code1 !== 4'(k % 16)) $display("FAIL dwell1_code k=%0d got=%0d exp=%0d", k, cur_code1, k % 16); else pass_cnt++;
         total_cnt++;
         if (wrap1 !== (k > 0 && k % 16 == 0)) $display("FAIL dwell1_wrap k=%0d got=%b exp=%b", k, wrap1, (k > 0 && k % 16 == 0)); else pass_cnt++;
      end
      repeat (20) tick();
      total_cnt++;
      if (cur_code !== 4'd7) $display("FAIL scan_code7 got=%0d exp=7", cur_code); else pass_cnt++;
   endtask

   task automatic test_mode_switch();
      mode = 1'b0;
      tick();
      total_cnt++;
      if (out !== exp_out(7)) $display("FAIL switch_out got=%h exp=%h", out, exp_out(7)); else pass_cnt++;
      total_cnt++;
      if (cur_code !== 4'd7) $display("FAIL switch_code got=%0d exp=7", cur_code); else pass_cnt++;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL switch_ready got=%b exp=1", in_ready); else pass_cnt++;
      repeat (3) tick();
      total_cnt++;
      if (cur_code !== 4'd7) $display("FAIL switch_hold got=%0d exp=7", cur_code); else pass_cnt++;
      in_valid = 1'b1; in_code = 4'd2;
      tick();
      in_valid = 1'b0;
      total_cnt++;
      if (out !== exp_out(2)) $display("FAIL switch_load_out got=%h exp=%h", out, exp_out(2)); else pass_cnt++;
      total_cnt++;
      if (wrap !== 1'b0) $display("FAIL switch_wrap got=%b exp=0", wrap); else pass_cnt++;
   endtask

   task automatic test_en_priority();
      en = 1'b0; in_valid = 1'b1; in_code = 4'd9;
      tick();
      total_cnt++;
      if (out !== POL) $display("FAIL en0_out got=%h exp=%h", out, POL); else pass_cnt++;
      total_cnt++;
      if (cur_code !== 4'd2) $display("FAIL en0_code got=%0d exp=2", cur_code); else pass_cnt++;
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL en0_ready got=%b exp=0", in_ready); else pass_cnt++;
      in_valid = 1'b0; mode = 1'b1;
      tick();
      total_cnt++;
      if (cur_code !== 4'd2) $display("FAIL en0_mode_code got=%0d exp=2", cur_code); else pass_cnt++;
      total_cnt++;
      if (out !== POL) $display("FAIL en0_mode_out got=%h exp=%h", out, POL); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      en = 1'b1; mode = 1'b0;
      tick();
      in_valid = 1'b1; in_code = 4'd11;
      tick();
      total_cnt++;
      if (cur_code !== 4'd11) $display("FAIL mid_load got=%0d exp=11", cur_code); else pass_cnt++;
      in_code = 4'd6;
      #2;
      rst = 1'b1;
      #1;
      total_cnt++;
      if (out !== POL) $display("FAIL async_out got=%h exp=%h", out, POL); else pass_cnt++;
      total_cnt++;
      if (cur_code !== 4'd0) $display("FAIL async_code got=%0d exp=0", cur_code); else pass_cnt++;
      total_cnt++;
      if (wrap !== 1'b0) $display("FAIL async_wrap got=%b exp=0", wrap); else pass_cnt++;
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL async_ready got=%b exp=0", in_ready); else pass_cnt++;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      tick();
      total_cnt++;
      if (cur_code !== 4'd0) $display("FAIL post_rst_code got=%0d exp=0", cur_code); else pass_cnt++;
      total_cnt++;
      if (out !== exp_out(0)) $display("FAIL post_rst_out got=%h exp=%h", out, exp_out(0)); else pass_cnt++;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL post_rst_ready got=%b exp=1", in_ready); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_direct();
      test_scan();
      test_mode_switch();
      test_en_priority();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
